conv_layer_sequencer: RTL and testbench

Parametrised successor of the convolution-layer controller. It sequences the input interface through PRELOAD / SHIFT / LOAD command rounds for a configurable number of weights, row shifts and frames, and runs under a start/done handshake instead of free-running. It reports protocol violations from the input interface. It sits between the layer top and the input interface and drives kernel-array clear plus a latency-aligned calc-finished strobe tagged with feature index and row.

---
 rtl/conv_ctrl_pkg.sv | 37 +++
 rtl/conv_layer_sequencer_if.sv | 29 ++
 rtl/conv_tag_delay.sv | 61 ++++++
 rtl/conv_layer_sequencer.sv | 155 +++++++++++++++
 tb/tb_conv_layer_sequencer.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/conv_ctrl_pkg.sv
// rtl/conv_ctrl_pkg.sv - shared command/ack encodings, state enum and sizing helpers
package conv_ctrl_pkg;

    localparam logic [1:0] CMD_IDLE    = 2'd0;
    localparam logic [1:0] CMD_PRELOAD = 2'd1;
    localparam logic [1:0] CMD_SHIFT   = 2'd2;
    localparam logic [1:0] CMD_LOAD    = 2'd3;

    localparam logic [1:0] ACK_NONE        = 2'd0;
    localparam logic [1:0] ACK_PRELOAD_FIN = 2'd1;
    localparam logic [1:0] ACK_SHIFT_FIN   = 2'd2;
    localparam logic [1:0] ACK_LOAD_FIN    = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PRELOAD = 3'd1,
        ST_SHIFT   = 3'd2,
        ST_LOAD    = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    // Counter/tag width for a count of n items; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // The only ack each state is waiting for; IDLE and DONE wait for none.
    function automatic logic [1:0] expected_ack(input state_t s);
        case (s)
            ST_PRELOAD: return ACK_PRELOAD_FIN;
            ST_SHIFT:   return ACK_SHIFT_FIN;
            ST_LOAD:    return ACK_LOAD_FIN;
            default:    return ACK_NONE;
        endcase
    endfunction

endpackage

// File: rtl/conv_layer_sequencer_if.sv
// rtl/conv_layer_sequencer_if.sv - control/handshake bundle between layer top, sequencer and input interface
interface conv_layer_sequencer_if #(
    parameter int IDX_W = 2,
    parameter int ROW_W = 3
);
    logic             enable;
    logic             start;
    logic [1:0]       input_interface_ack;
    logic [1:0]       input_interface_cmd;
    logic             kernel_array_clear;
    logic             kernel_calc_fin;
    logic [IDX_W-1:0] feature_idx;
    logic [ROW_W-1:0] feature_row;
    logic             busy;
    logic             done;
    logic             ack_error;

    modport master (
        output enable, start, input_interface_ack,
        input  input_interface_cmd, kernel_array_clear, kernel_calc_fin,
               feature_idx, feature_row, busy, done, ack_error
    );

    modport slave (
        input  enable, start, input_interface_ack,
        output input_interface_cmd, kernel_array_clear, kernel_calc_fin,
               feature_idx, feature_row, busy, done, ack_error
    );
endinterface

// File: rtl/conv_tag_delay.sv
// rtl/conv_tag_delay.sv - fixed-latency shift register carrying {valid, idx, row} calc tags
module conv_tag_delay #(
    parameter int DEPTH = 3,
    parameter int IDX_W = 2,
    parameter int ROW_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_valid,
    input  logic [IDX_W-1:0] i_idx,
    input  logic [ROW_W-1:0] i_row,
    output logic             o_valid,
    output logic [IDX_W-1:0] o_idx,
    output logic [ROW_W-1:0] o_row
);

    logic [DEPTH-1:0] r_valid;
    logic [IDX_W-1:0] r_idx [DEPTH];
    logic [ROW_W-1:0] r_row [DEPTH];

    logic [DEPTH-1:0] w_src_valid;
    logic [IDX_W-1:0] w_src_idx [DEPTH];
    logic [ROW_W-1:0] w_src_row [DEPTH];

    // Source of each stage: the input for stage 0, the previous stage otherwise.
    always_comb begin
        w_src_valid[0] = i_valid;
        w_src_idx[0]   = i_idx;
        w_src_row[0]   = i_row;
        for (int i = 1; i < DEPTH; i++) begin
            w_src_valid[i] = r_valid[i-1];
            w_src_idx[i]   = r_idx[i-1];
            w_src_row[i]   = r_row[i-1];
        end
    end

    // Valid shifts every cycle; a tag only moves with a valid bit, so the
    // last stage holds the most recently finished tag between pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_idx[i] <= '0;
                r_row[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                r_valid[i] <= w_src_valid[i];
                if (w_src_valid[i]) begin
                    r_idx[i] <= w_src_idx[i];
                    r_row[i] <= w_src_row[i];
                end
            end
        end
    end

    assign o_valid = r_valid[DEPTH-1];
    assign o_idx   = r_idx[DEPTH-1];
    assign o_row   = r_row[DEPTH-1];

endmodule

// File: rtl/conv_layer_sequencer.sv
// rtl/conv_layer_sequencer.sv - PRELOAD/SHIFT/LOAD round sequencer with start/done handshake
module conv_layer_sequencer
    import conv_ctrl_pkg::*;
#(
    parameter int TOTAL_WEIGHT = 3,
    parameter int TOTAL_SHIFT  = 6,
    parameter int TOTAL_FRAME  = 1,
    parameter int CALC_LATENCY = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    conv_layer_sequencer_if.slave bus
);

    localparam int IW = cnt_width(TOTAL_WEIGHT);
    localparam int RW = cnt_width(TOTAL_SHIFT);
    localparam int FW = cnt_width(TOTAL_FRAME);
    localparam logic [IW-1:0] W_LAST = IW'(TOTAL_WEIGHT - 1);
    localparam logic [RW-1:0] S_LAST = RW'(TOTAL_SHIFT - 1);
    localparam logic [FW-1:0] F_LAST = FW'(TOTAL_FRAME - 1);

    state_t          r_state, w_state_nxt;
    logic [IW-1:0]   r_w, w_w_nxt;
    logic [RW-1:0]   r_s, w_s_nxt;
    logic [FW-1:0]   r_f, w_f_nxt;

    logic [1:0]      r_cmd, w_cmd_nxt;
    logic            r_clear, w_clear_nxt;
    logic            r_ack_err, w_ack_err_nxt;

    logic            w_start_ok;
    logic            w_accept;
    logic            w_shift_fin;
    logic            w_calc_fin;
    logic [IW-1:0]   w_tag_idx;
    logic [RW-1:0]   w_tag_row;

    // An ack counts only while enabled and only if it is the one this state awaits.
    assign w_start_ok  = bus.enable && bus.start && (r_state == ST_IDLE);
    assign w_accept    = bus.enable && (bus.input_interface_ack != ACK_NONE) &&
                         (bus.input_interface_ack == expected_ack(r_state));
    assign w_shift_fin = w_accept && (r_state == ST_SHIFT);

    // State and round counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_w     <= '0;
            r_s     <= '0;
            r_f     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_w     <= w_w_nxt;
            r_s     <= w_s_nxt;
            r_f     <= w_f_nxt;
        end
    end

    // Next state: weight is the innermost loop, then row shift, then frame.
    always_comb begin
        w_state_nxt = r_state;
        w_w_nxt     = r_w;
        w_s_nxt     = r_s;
        w_f_nxt     = r_f;
        case (r_state)
            ST_IDLE: begin
                if (w_start_ok) w_state_nxt = ST_PRELOAD;
            end
            ST_PRELOAD: begin
                if (w_accept) w_state_nxt = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (w_accept) begin
                    if (r_w < W_LAST) begin
                        w_w_nxt = r_w + 1'b1;
                    end else begin
                        w_w_nxt = '0;
                        if (r_s < S_LAST) begin
                            w_s_nxt     = r_s + 1'b1;
                            w_state_nxt = ST_LOAD;
                        end else begin
                            w_s_nxt = '0;
                            if (r_f < F_LAST) begin
                                w_f_nxt     = r_f + 1'b1;
                                w_state_nxt = ST_PRELOAD;
                            end else begin
                                w_f_nxt     = '0;
                                w_state_nxt = ST_DONE;
                            end
                        end
                    end
                end
            end
            ST_LOAD: begin
                if (w_accept) w_state_nxt = ST_SHIFT;
            end
            // DONE always retires so done stays a single-cycle pulse.
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Output decode: a command is issued only on the cycle a transition is taken.
    always_comb begin
        w_cmd_nxt = CMD_IDLE;
        if (w_start_ok || w_accept) begin
            case (w_state_nxt)
                ST_PRELOAD: w_cmd_nxt = CMD_PRELOAD;
                ST_SHIFT:   w_cmd_nxt = CMD_SHIFT;
                ST_LOAD:    w_cmd_nxt = CMD_LOAD;
                default:    w_cmd_nxt = CMD_IDLE;
            endcase
        end
        w_clear_nxt   = w_shift_fin;
        w_ack_err_nxt = (bus.input_interface_ack != ACK_NONE) && !w_accept;
    end

    // Registered command, clear and error strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cmd     <= CMD_IDLE;
            r_clear   <= 1'b0;
            r_ack_err <= 1'b0;
        end else begin
            r_cmd     <= w_cmd_nxt;
            r_clear   <= w_clear_nxt;
            r_ack_err <= w_ack_err_nxt;
        end
    end

    conv_tag_delay #(
        .DEPTH (CALC_LATENCY),
        .IDX_W (IW),
        .ROW_W (RW)
    ) u_tag_delay (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (w_shift_fin),
        .i_idx   (r_w),
        .i_row   (r_s),
        .o_valid (w_calc_fin),
        .o_idx   (w_tag_idx),
        .o_row   (w_tag_row)
    );

    assign bus.input_interface_cmd = r_cmd;
    assign bus.kernel_array_clear  = r_clear;
    assign bus.ack_error           = r_ack_err;
    assign bus.kernel_calc_fin     = w_calc_fin;
    assign bus.feature_idx         = w_tag_idx;
    assign bus.feature_row         = w_tag_row;
    assign bus.busy                = (r_state != ST_IDLE);
    assign bus.done                = (r_state == ST_DONE);

endmodule

// File: tb/tb_conv_layer_sequencer.sv
// tb/tb_conv_layer_sequencer.sv - randomized self-checking bench for conv_layer_sequencer
module tb_conv_layer_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    // Drive/observe arrays: index 0 = default config, index 1 = 2x2x2 with latency 1.
    logic       en    [2];
    logic       st    [2];
    logic [1:0] ack_d [2];
    logic [1:0] cmd_o [2];
    logic       clr_o [2];
    logic       calc_o[2];
    logic [7:0] idx_o [2];
    logic [7:0] row_o [2];
    logic       busy_o[2];
    logic       done_o[2];
    logic       err_o [2];

    conv_layer_sequencer_if #(.IDX_W(2), .ROW_W(3)) if0 ();
    conv_layer_sequencer_if #(.IDX_W(1), .ROW_W(1)) if1 ();

    conv_layer_sequencer u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    conv_layer_sequencer #(
        .TOTAL_WEIGHT(2), .TOTAL_SHIFT(2), .TOTAL_FRAME(2), .CALC_LATENCY(1)
    ) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

    assign if0.enable = en[0];
    assign if0.start  = st[0];
    assign if0.input_interface_ack = ack_d[0];
    assign if1.enable = en[1];
    assign if1.start  = st[1];
    assign if1.input_interface_ack = ack_d[1];

    assign cmd_o[0]  = if0.input_interface_cmd;
    assign clr_o[0]  = if0.kernel_array_clear;
    assign calc_o[0] = if0.kernel_calc_fin;
    assign idx_o[0]  = 8'(if0.feature_idx);
    assign row_o[0]  = 8'(if0.feature_row);
    assign busy_o[0] = if0.busy;
    assign done_o[0] = if0.done;
    assign err_o[0]  = if0.ack_error;
    assign cmd_o[1]  = if1.input_interface_cmd;
    assign clr_o[1]  = if1.kernel_array_clear;
    assign calc_o[1] = if1.kernel_calc_fin;
    assign idx_o[1]  = 8'(if1.feature_idx);
    assign row_o[1]  = 8'(if1.feature_row);
    assign busy_o[1] = if1.busy;
    assign done_o[1] = if1.done;
    assign err_o[1]  = if1.ack_error;

    function automatic int tw_of(input int k); return (k == 0) ? 3 : 2; endfunction
    function automatic int ts_of(input int k); return (k == 0) ? 6 : 2; endfunction
    function automatic int tf_of(input int k); return (k == 0) ? 1 : 2; endfunction
    function automatic int cl_of(input int k); return (k == 0) ? 3 : 1; endfunction

    // Observation log of the DUT currently under test.
    int act = 0;
    int cmdq[$], tagq[$], calcc[$], clrc[$], sackq[$];
    int done_cnt = 0, err_cnt = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (cmd_o[act] != 2'd0) cmdq.push_back(int'(cmd_o[act]));
            if (calc_o[act]) begin
                tagq.push_back(int'(idx_o[act]) * 256 + int'(row_o[act]));
                calcc.push_back(cyc);
            end
            if (clr_o[act])  clrc.push_back(cyc);
            if (done_o[act]) done_cnt++;
            if (err_o[act])  err_cnt++;
        end
    end

    task automatic clear_log();
        cmdq.delete(); tagq.delete(); calcc.delete(); clrc.delete(); sackq.delete();
        done_cnt = 0; err_cnt = 0;
    endtask

    task automatic check_all_zero(input int k, input string tag);
        total++; if (cmd_o[k]  !== 2'd0) begin bad++; $display("FAIL %s_cmd[%0d]: got %0d want 0", tag, k, cmd_o[k]); end
        total++; if (clr_o[k]  !== 1'b0) begin bad++; $display("FAIL %s_clear[%0d]: got %0b want 0", tag, k, clr_o[k]); end
        total++; if (calc_o[k] !== 1'b0) begin bad++; $display("FAIL %s_calc[%0d]: got %0b want 0", tag, k, calc_o[k]); end
        total++; if (idx_o[k]  !== 8'd0) begin bad++; $display("FAIL %s_idx[%0d]: got %0d want 0", tag, k, idx_o[k]); end
        total++; if (row_o[k]  !== 8'd0) begin bad++; $display("FAIL %s_row[%0d]: got %0d want 0", tag, k, row_o[k]); end
        total++; if (busy_o[k] !== 1'b0) begin bad++; $display("FAIL %s_busy[%0d]: got %0b want 0", tag, k, busy_o[k]); end
        total++; if (done_o[k] !== 1'b0) begin bad++; $display("FAIL %s_done[%0d]: got %0b want 0", tag, k, done_o[k]); end
        total++; if (err_o[k]  !== 1'b0) begin bad++; $display("FAIL %s_err[%0d]: got %0b want 0", tag, k, err_o[k]); end
    endtask

    // One job on DUT k. dly: ack delay in cycles after the cmd (0 = random 1..3).
    // inj: 0 none, 1 wrong ack in SHIFT, 2 five-cycle enable pause, 3 reset at (w=1,s=3).
    task automatic run_job(input int k, input int dly, input int inj);
        int ecmd[$], etag[$];
        int ncmd, nshift, waitc, dcyc, exp_err;
        logic [1:0] pend;
        bit got_done, aborted;
        ncmd = 0; nshift = 0; waitc = 0; pend = 2'd0; got_done = 0; aborted = 0;
        exp_err = (inj == 1 || inj == 2) ? 1 : 0;
        for (int f = 0; f < tf_of(k); f++) begin
            ecmd.push_back(1);
            for (int s = 0; s < ts_of(k); s++) begin
                if (s > 0) ecmd.push_back(3);
                for (int w = 0; w < tw_of(k); w++) begin
                    ecmd.push_back(2);
                    etag.push_back(w * 256 + s);
                end
            end
        end
        act = k;
        en[k] = 1'b1;
        clear_log();
        st[k] = 1'b1;
        @(negedge clk);
        st[k] = 1'b0;
        total++; if (busy_o[k] !== 1'b1) begin bad++; $display("FAIL start_busy[%0d]: got %0b want 1", k, busy_o[k]); end
        for (int n = 0; n < 4000; n++) begin
            logic [1:0] c;
            c = cmd_o[k];
            ack_d[k] = 2'd0;
            st[k] = 1'b0;
            if (done_o[k]) begin got_done = 1; break; end
            if (c != 2'd0) begin
                ncmd++;
                if (c == 2'd2) nshift++;
                pend  = c;
                waitc = (dly == 0) ? int'($urandom_range(2, 0)) : dly - 1;
                if (inj == 3 && c == 2'd2 && nshift == 11) begin
                    rst_n = 1'b0;
                    #1;
                    check_all_zero(k, "midrst");
                    aborted = 1;
                    break;
                end
                if (inj == 1 && ncmd == 2) begin
                    ack_d[k] = 2'd3;
                    st[k] = 1'b1;
                    @(negedge clk);
                    ack_d[k] = 2'd0;
                    st[k] = 1'b0;
                    total++; if (err_o[k] !== 1'b1) begin bad++; $display("FAIL badack_err: got %0b want 1", err_o[k]); end
                    total++; if (cmd_o[k] !== 2'd0) begin bad++; $display("FAIL badack_cmd: got %0d want 0", cmd_o[k]); end
                    total++; if (clr_o[k] !== 1'b0) begin bad++; $display("FAIL badack_clear: got %0b want 0", clr_o[k]); end
                end
                if (inj == 2 && ncmd == 3) begin
                    en[k] = 1'b0;
                    for (int i = 0; i < 5; i++) begin
                        ack_d[k] = (i == 2) ? c : 2'd0;
                        @(negedge clk);
                        total++; if (cmd_o[k] !== 2'd0) begin bad++; $display("FAIL pause_cmd[%0d]: got %0d want 0", i, cmd_o[k]); end
                        total++; if (err_o[k] !== (i == 2)) begin bad++; $display("FAIL pause_err[%0d]: got %0b want %0b", i, err_o[k], (i == 2)); end
                    end
                    ack_d[k] = 2'd0;
                    en[k] = 1'b1;
                end
            end
            if (pend != 2'd0) begin
                if (waitc == 0) begin
                    ack_d[k] = pend;
                    if (pend == 2'd2) sackq.push_back(cyc);
                    pend = 2'd0;
                end else begin
                    waitc--;
                end
            end
            if (ack_d[k] == 2'd0 && $urandom_range(4, 0) == 0) st[k] = 1'b1;
            @(negedge clk);
        end
        ack_d[k] = 2'd0;
        st[k] = 1'b0;
        if (aborted) return;
        if (!got_done) begin
            total++; bad++;
            $display("FAIL job_timeout[%0d]: got no done want done within 4000 cycles", k);
            return;
        end
        dcyc = cyc;
        total++; if (busy_o[k] !== 1'b1) begin bad++; $display("FAIL done_busy[%0d]: got %0b want 1", k, busy_o[k]); end
        @(negedge clk);
        total++; if (busy_o[k] !== 1'b0) begin bad++; $display("FAIL after_done_busy[%0d]: got %0b want 0", k, busy_o[k]); end
        total++; if (done_o[k] !== 1'b0) begin bad++; $display("FAIL done_pulse[%0d]: got %0b want 0", k, done_o[k]); end
        repeat (cl_of(k) + 2) @(negedge clk);

        total++;
        if (cmdq.size() != ecmd.size()) begin
            bad++; $display("FAIL cmd_count[%0d]: got %0d want %0d", k, cmdq.size(), ecmd.size());
        end else begin
            for (int i = 0; i < ecmd.size(); i++) begin
                total++;
                if (cmdq[i] != ecmd[i]) begin bad++; $display("FAIL cmd_seq[%0d] #%0d: got %0d want %0d", k, i, cmdq[i], ecmd[i]); break; end
            end
        end
        total++;
        if (tagq.size() != etag.size()) begin
            bad++; $display("FAIL calc_count[%0d]: got %0d want %0d", k, tagq.size(), etag.size());
        end else begin
            for (int i = 0; i < etag.size(); i++) begin
                total++;
                if (tagq[i] != etag[i]) begin bad++; $display("FAIL calc_tag[%0d] #%0d: got idx=%0d row=%0d want idx=%0d row=%0d", k, i, tagq[i] / 256, tagq[i] % 256, etag[i] / 256, etag[i] % 256); break; end
            end
        end
        total++;
        if (calcc.size() != sackq.size() || clrc.size() != sackq.size()) begin
            bad++; $display("FAIL strobe_count[%0d]: got calc=%0d clear=%0d want %0d", k, calcc.size(), clrc.size(), sackq.size());
        end else begin
            for (int i = 0; i < sackq.size(); i++) begin
                total++;
                if (calcc[i] != sackq[i] + cl_of(k)) begin bad++; $display("FAIL calc_latency[%0d] #%0d: got cycle %0d want %0d", k, i, calcc[i], sackq[i] + cl_of(k)); break; end
                total++;
                if (clrc[i] != sackq[i] + 1) begin bad++; $display("FAIL clear_latency[%0d] #%0d: got cycle %0d want %0d", k, i, clrc[i], sackq[i] + 1); break; end
            end
        end
        if (sackq.size() > 0) begin
            total++;
            if (dcyc != sackq[sackq.size() - 1] + 1) begin bad++; $display("FAIL done_latency[%0d]: got cycle %0d want %0d", k, dcyc, sackq[sackq.size() - 1] + 1); end
        end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL done_count[%0d]: got %0d want 1", k, done_cnt); end
        total++; if (err_cnt != exp_err) begin bad++; $display("FAIL err_count[%0d]: got %0d want %0d", k, err_cnt, exp_err); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin en[k] = 1'b1; st[k] = 1'b0; ack_d[k] = 2'd0; end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) check_all_zero(k, "reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 2; k++) check_all_zero(k, "post_reset");
    endtask

    task automatic test_default_job();    run_job(0, 2, 0); endtask
    task automatic test_small_config();   run_job(1, 0, 0); endtask
    task automatic test_back_to_back();   run_job(0, 1, 0); run_job(1, 1, 0); endtask
    task automatic test_bad_ack();        run_job(0, 2, 1); endtask
    task automatic test_enable_pause();   run_job(0, 2, 2); endtask

    task automatic test_reset_mid_job();
        run_job(0, 2, 3);
        @(negedge clk);
        clear_log();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        total++; if (tagq.size() != 0) begin bad++; $display("FAIL stale_calc: got %0d pulses want 0", tagq.size()); end
        total++; if (busy_o[0] !== 1'b0) begin bad++; $display("FAIL stale_busy: got %0b want 0", busy_o[0]); end
        run_job(0, 2, 0);
    endtask

    task automatic test_random_jobs();
        for (int r = 0; r < 4; r++) run_job(int'($urandom_range(1, 0)), 0, 0);
    endtask

    initial begin
        test_reset();
        test_default_job();
        test_small_config();
        test_back_to_back();
        test_bad_ack();
        test_enable_pause();
        test_reset_mid_job();
        test_random_jobs();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
